// File: rtl/shmem_bank_arb.sv
// -----------------------------------------------------------------------------
// shmem_bank_arb
//
// One bank of shared memory serving NUM_PORTS requesters through a single
// memory port. A round-robin arbiter accepts at most one request per cycle.
// The response comes back one cycle after the accept, tagged with a one-hot
// strobe for the accepted port. Requests to addresses >= DEPTH do not touch
// the memory and are answered with rsp_error. A saturating counter records
// cycles in which two or more ports are requesting at once (bank conflicts).
//
// Optional feature: define SHMEM_BANK_WSTRB_EN to add req_strb and byte-masked
// writes. Without it, every write replaces the full word.
//
// Ports:
//   clock        rising-edge clock for all state
//   reset        asynchronous, active-low reset
//   req_valid    per-port request valid
//   req_write    per-port write (1) / read (0)
//   req_addr     packed addresses, port p at [p*ADDR_W +: ADDR_W]
//   req_data     packed write data, port p at [p*DATA_W +: DATA_W]
//   req_strb     packed byte strobes (only with SHMEM_BANK_WSTRB_EN)
//   req_ready    one-hot grant, combinational from req_valid and pointer
//   rsp_valid    one-hot registered response strobe
//   rsp_data     read data; 0 for writes, errors and idle cycles
//   rsp_error    response address was >= DEPTH
//   cnt_clear    synchronous clear of conflict_cnt (wins over increment)
//   conflict_cnt saturating count of conflict cycles
// -----------------------------------------------------------------------------
module shmem_bank_arb #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int NUM_PORTS = 4,
    parameter int CNT_W     = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]     req_data,
`ifdef SHMEM_BANK_WSTRB_EN
    input  logic [NUM_PORTS*(DATA_W/8)-1:0] req_strb,
`endif
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic [NUM_PORTS-1:0]            rsp_valid,
    output logic [DATA_W-1:0]               rsp_data,
    output logic                            rsp_error,
    input  logic                            cnt_clear,
    output logic [CNT_W-1:0]                conflict_cnt
);

    localparam int PTR_W  = $clog2(NUM_PORTS);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STRB_W = DATA_W / 8;

    logic [PTR_W-1:0]  last;        // index of the most recently granted port
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  cand_idx;
    logic              any_valid;
    int                cand_sum;

    // Round-robin search: start just after `last`, wrap, first valid wins.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value held and infer a latch.
    always_comb begin
        grant_idx = last;
        any_valid = 1'b0;
        cand_sum  = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand_sum = int'(last) + i;
            if (cand_sum >= NUM_PORTS) begin
                cand_sum = cand_sum - NUM_PORTS;
            end
            cand_idx = PTR_W'(cand_sum);
            if (!any_valid && req_valid[cand_idx]) begin
                any_valid = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (any_valid) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Fields of the granted request.
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_range;
    logic [IDX_W-1:0]  mem_idx;
    logic              do_write;
    logic              do_read;
    logic              conflict;

    assign sel_write = req_write[grant_idx];
    assign sel_addr  = req_addr[grant_idx*ADDR_W +: ADDR_W];
    assign sel_wdata = req_data[grant_idx*DATA_W +: DATA_W];
    // One extra bit keeps the compare correct when DEPTH == 2**ADDR_W.
    assign in_range  = ({1'b0, sel_addr} < (ADDR_W+1)'(DEPTH));
    assign mem_idx   = sel_addr[IDX_W-1:0];
    assign do_write  = any_valid && sel_write && in_range;
    assign do_read   = any_valid && !sel_write && in_range;
    assign conflict  = ($countones(req_valid) >= 2);

`ifdef SHMEM_BANK_WSTRB_EN
    logic [STRB_W-1:0] sel_strb;
    assign sel_strb = req_strb[grant_idx*STRB_W +: STRB_W];
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage array is deliberately left out of reset; clearing it
    // would cost a write port per word and nothing depends on its contents
    // after reset.
    always_ff @(posedge clock) begin
        if (do_write) begin
`ifdef SHMEM_BANK_WSTRB_EN
            for (int b = 0; b < STRB_W; b++) begin
                if (sel_strb[b]) begin
                    mem[mem_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
`else
            mem[mem_idx] <= sel_wdata;
`endif
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last         <= PTR_W'(NUM_PORTS - 1);
            rsp_valid    <= '0;
            rsp_data     <= '0;
            rsp_error    <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            rsp_valid <= req_ready;
            rsp_error <= any_valid && !in_range;
            // Read returns the word as it was before this edge's write slot.
            rsp_data  <= do_read ? mem[mem_idx] : '0;
            if (any_valid) begin
                last <= grant_idx;
            end
            if (cnt_clear) begin
                conflict_cnt <= '0;
            end else if (conflict && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shmem_bank_arb.sv
// -----------------------------------------------------------------------------
// tb_shmem_bank_arb
//
// Self-checking bench for shmem_bank_arb (DEPTH = 200, CNT_W = 3, 4 ports).
// A behavioural model tracks pending requests per port, picks the winner by
// the "first valid port after the last grant" rule, keeps an array image of
// the memory and a saturating conflict count. Directed steps cover reset,
// single-port write/read, round-robin order, counter saturation and clear,
// out-of-range access and reset while a response is in flight; a randomized
// phase follows. With SHMEM_BANK_WSTRB_EN the word is 16 bits and byte
// strobes are exercised.
// -----------------------------------------------------------------------------
module tb_shmem_bank_arb;

    localparam int NP      = 4;
    localparam int AW      = 8;
    localparam int DEPTH   = 200;
    localparam int CNTW    = 3;
    localparam int CNT_MAX = (1 << CNTW) - 1;
`ifdef SHMEM_BANK_WSTRB_EN
    localparam int DW = 16;
`else
    localparam int DW = 8;
`endif
    localparam int SW = DW / 8;

    logic                 clock;
    logic                 reset;
    logic [NP-1:0]        req_valid;
    logic [NP-1:0]        req_write;
    logic [NP*AW-1:0]     req_addr;
    logic [NP*DW-1:0]     req_data;
    logic [NP*SW-1:0]     req_strb;
    logic [NP-1:0]        req_ready;
    logic [NP-1:0]        rsp_valid;
    logic [DW-1:0]        rsp_data;
    logic                 rsp_error;
    logic                 cnt_clear;
    logic [CNTW-1:0]      conflict_cnt;

    shmem_bank_arb #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .DEPTH     (DEPTH),
        .NUM_PORTS (NP),
        .CNT_W     (CNTW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_data     (req_data),
`ifdef SHMEM_BANK_WSTRB_EN
        .req_strb     (req_strb),
`endif
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_error    (rsp_error),
        .cnt_clear    (cnt_clear),
        .conflict_cnt (conflict_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- reference model state ----------------
    bit            pv [NP];           // request pending on port
    bit            pw [NP];
    int            pa [NP];
    logic [DW-1:0] pd [NP];
    logic [SW-1:0] ps [NP];
    logic [DW-1:0] mdl_mem [256];
    int            last_m;
    int            cnt_m;
    logic [NP-1:0] exp_rv;
    logic [DW-1:0] exp_rd;
    logic          exp_re;

    // observed values from the most recent cycle() sample point
    logic [NP-1:0]   obs_ready;
    logic [NP-1:0]   obs_rv;
    logic [DW-1:0]   obs_rd;
    logic            obs_re;
    logic [CNTW-1:0] obs_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic post(input int p, input bit w, input int a,
                        input logic [DW-1:0] d, input logic [SW-1:0] s);
        pv[p] = 1'b1;
        pw[p] = w;
        pa[p] = a;
        pd[p] = d;
        ps[p] = s;
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            req_valid[p]           = pv[p];
            req_write[p]           = pw[p];
            req_addr[p*AW +: AW]   = AW'(pa[p]);
            req_data[p*DW +: DW]   = pd[p];
            req_strb[p*SW +: SW]   = ps[p];
        end
    endtask

    // One clock cycle: drive, sample/check at negedge, advance model at posedge.
    task automatic cycle(input logic cc);
        int            g;
        int            nv;
        int            a;
        int            q;
        logic [NP-1:0] exp_ready;
        cnt_clear = cc;
        drive();
        @(negedge clock);
        g = -1;
        for (int i = 1; i <= NP; i++) begin
            q = (last_m + i) % NP;
            if (g < 0 && pv[q]) g = q;
        end
        exp_ready = (g >= 0) ? (NP'(1) << g) : '0;
        obs_ready = req_ready;
        obs_rv    = rsp_valid;
        obs_rd    = rsp_data;
        obs_re    = rsp_error;
        obs_cnt   = conflict_cnt;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        check("rsp_data", 32'(rsp_data), 32'(exp_rd));
        check("rsp_error", 32'(rsp_error), 32'(exp_re));
        check("conflict_cnt", 32'(conflict_cnt), 32'(cnt_m));
        @(posedge clock);
        nv = 0;
        for (int p = 0; p < NP; p++) nv += int'(pv[p]);
        if (cc) cnt_m = 0;
        else if (nv >= 2 && cnt_m < CNT_MAX) cnt_m++;
        exp_rv = '0;
        exp_rd = '0;
        exp_re = 1'b0;
        if (g >= 0) begin
            exp_rv = NP'(1) << g;
            a = pa[g];
            if (a >= DEPTH) begin
                exp_re = 1'b1;
            end else if (!pw[g]) begin
                exp_rd = mdl_mem[a];
            end else begin
                for (int b = 0; b < SW; b++) begin
                    if (ps[g][b]) mdl_mem[a][b*8 +: 8] = pd[g][b*8 +: 8];
                end
            end
            last_m = g;
            pv[g]  = 1'b0;
        end
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        cnt_clear = 1'b0;
        for (int p = 0; p < NP; p++) pv[p] = 1'b0;
        drive();
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
        last_m = NP - 1;
        cnt_m  = 0;
        exp_rv = '0;
        exp_rd = '0;
        exp_re = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * NP; k++) begin
            if (pv[0] || pv[1] || pv[2] || pv[3]) cycle(1'b0);
        end
    endtask

    function automatic int rand_addr();
        int i;
        i = int'($urandom_range(0, 15));
        return (i < 8) ? i : 188 + i;   // 0..7 and 196..203 (200..203 out of range)
    endfunction

    initial begin
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_data  = '0;
        req_strb  = '0;
        cnt_clear = 1'b0;
        for (int p = 0; p < NP; p++) begin
            pv[p] = 1'b0; pw[p] = 1'b0; pa[p] = 0; pd[p] = '0; ps[p] = '1;
        end
        apply_reset();

        // Single port: write 0xA5 to 0x10, read it back next cycle.
        post(0, 1'b1, 'h10, DW'('hA5), '1);
        cycle(1'b0);
        post(0, 1'b0, 'h10, '0, '1);
        cycle(1'b0);
        check("wr_rsp_valid", 32'(obs_rv), 32'b0001);
        check("wr_rsp_data", 32'(obs_rd), 32'd0);
        cycle(1'b0);
        check("rd_rsp_valid", 32'(obs_rv), 32'b0001);
        check("rd_rsp_data", 32'(obs_rd), 32'hA5);
        check("rd_rsp_error", 32'(obs_re), 32'd0);

        // Fill every in-range address the random phase will touch.
        for (int i = 0; i < 12; i++) begin
            post(i % NP, 1'b1, (i < 8) ? i : 188 + i, DW'($urandom), '1);
            cycle(1'b0);
        end

        // Round-robin from reset: grants 0,1,2,3,0,1,2,3; counter saturates.
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            for (int p = 0; p < NP; p++) if (!pv[p]) post(p, 1'b0, 'h10, '0, '1);
            cycle(1'b0);
            if (i < 8) check("rr_grant", 32'(obs_ready), 32'(1 << (i % NP)));
        end
        cycle(1'b1);                       // clear during a conflict cycle
        check("cnt_saturated", 32'(obs_cnt), 32'(CNT_MAX));
        cycle(1'b0);
        check("cnt_cleared", 32'(obs_cnt), 32'd0);
        drain();

        // Out of range: write and read address 200 must not touch memory.
        post(0, 1'b1, 0, DW'('h3C), '1);
        cycle(1'b0);
        post(0, 1'b1, 200, DW'('h5A), '1);
        cycle(1'b0);
        post(0, 1'b0, 200, '0, '1);
        cycle(1'b0);
        check("oor_wr_error", 32'(obs_re), 32'd1);
        post(0, 1'b0, 0, '0, '1);
        cycle(1'b0);
        check("oor_rd_error", 32'(obs_re), 32'd1);
        check("oor_rd_data", 32'(obs_rd), 32'd0);
        cycle(1'b0);
        check("oor_untouched", 32'(obs_rd), 32'h3C);

        // Reset with a read response in flight.
        post(1, 1'b0, 'h10, '0, '1);
        cycle(1'b0);
        apply_reset();
        cycle(1'b0);
        check("rst_drop_rsp", 32'(obs_rv), 32'd0);
        for (int p = 0; p < NP; p++) post(p, 1'b0, 'h10, '0, '1);
        cycle(1'b0);
        check("rst_first_grant", 32'(obs_ready), 32'b0001);
        drain();

`ifdef SHMEM_BANK_WSTRB_EN
        // Byte strobes: only the low byte of the second write lands.
        post(2, 1'b1, 'h20, DW'('hFFFF), '1);
        cycle(1'b0);
        post(2, 1'b1, 'h20, DW'('h1234), SW'(1));
        cycle(1'b0);
        post(2, 1'b0, 'h20, '0, '1);
        cycle(1'b0);
        cycle(1'b0);
        check("strb_merge", 32'(obs_rd), 32'hFF34);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (!pv[p] && $urandom_range(0, 2) != 0) begin
`ifdef SHMEM_BANK_WSTRB_EN
                    post(p, 1'($urandom), rand_addr(), DW'($urandom), SW'($urandom));
`else
                    post(p, 1'($urandom), rand_addr(), DW'($urandom), '1);
`endif
                end
            end
            cycle($urandom_range(0, 19) == 0);
        end
        drain();
        cycle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
